branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer with per-entry 2-bit prediction counters, located in the IF stage. It supplies the PC-match, predicted-target and counter values that the hazard/branch logic compares in ID/EX. It also commits the counter/target updates that the branch unit produces through its write-enable and control-out signals. Lookup results are registered into an IF/ID side register that follows the pipeline's stall and flush controls.

## Interface
- ENTRIES, 16: number of entries; power of two, 4..256
- IDX_W, log2(ENTRIES): index width (derived, do not override)
- CNT_W, 16: width of the statistics counters

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous active-low reset
- i_PC  input  32  IF-stage fetch PC
- i_PC_Stall  input  1  IF stage held this cycle
- i_IFID_Stall  input  1  hold the IF/ID side register
- i_Flush_IF_ID  input  1  clear the IF/ID side register
- i_Invalidate  input  1  clear every valid bit
- i_Upd_WE  input  1  write an entry (from the branch unit's WriteEnable)
- i_Upd_PC  input  32  PC of the resolved branch
- i_Upd_Target  input  32  resolved target
- i_Upd_Ctrl  input  2  new counter value (from the branch unit's CtrlOut)
- o_Hit  output  1  combinational lookup hit
- o_PredTaken  output  1  combinational: o_Hit & counter[1]
- o_PredTarget  output  32  combinational predicted target; 0 on miss
- o_IFID_PcMatchValid  output  1  registered hit, feeds PcMatchValid
- o_IFID_Ctrl  output  2  registered counter, feeds CtrlIn
- o_IFID_Target  output  32  registered predicted target
- o_Hit_Count  output  CNT_W  saturating count of lookup hits
- o_Upd_Count  output  CNT_W  saturating count of entry writes

## Operation
- Index is PC[IDX_W+1:2]. Tag is PC[31:IDX_W+2]. PC[1:0] are ignored.
- Each entry holds: valid, tag, target[31:0], ctrl[1:0].
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. The block stores i_Upd_Ctrl verbatim and does no counter arithmetic itself.
- Lookup:
  - Hit = valid && tag match on the entry selected by i_PC.
  - On a miss: o_PredTaken=0, o_PredTarget=0, and o_IFID_Ctrl is captured as 01.
- Write-first bypass: when i_Upd_WE=1 and i_Upd_PC has the same index and tag as i_PC, the lookup outputs use i_Upd_Target/i_Upd_Ctrl with hit=1 in that same cycle. This does not apply when i_Invalidate=1.
- Update: when i_Upd_WE=1, the entry at the index of i_Upd_PC is overwritten with valid=1, the new tag, target and ctrl. Any previous entry at that index (alias) is replaced.
- Invalidate:
  - i_Invalidate=1 clears all valid bits at the edge.
  - It has priority over a same-cycle update: the update is dropped and o_Upd_Count does not increment.
- IF/ID side register, priority order:
  - i_Flush_IF_ID: load {0, 01, 0}.
  - else i_IFID_Stall: hold.
  - else: load {o_Hit, ctrl or 01, o_PredTarget}.
- o_Hit_Count increments when o_Hit=1 and i_PC_Stall=0. It saturates at all-ones.
- o_Upd_Count increments on each accepted write. It saturates at all-ones.

## Timing
- Reset (rst=0, asynchronous):
  - All valid bits are 0.
  - o_IFID_PcMatchValid=0, o_IFID_Ctrl=01, o_IFID_Target=0.
  - Both counters are 0.
  - Tag, target and ctrl storage are not reset.
  - Reset mid-operation discards any pending write.
- Lookup latency is 0 cycles, combinational from i_PC and the update bus. IF/ID outputs follow 1 cycle later.
- A write at edge N is visible to the non-bypassed lookup from cycle N+1.
- A write and a lookup to the same index with a different tag in the same cycle: the lookup returns the old contents (no bypass).
- Flush has priority over stall in the same cycle.
- There is no handshake: every asserted i_Upd_WE is accepted at the edge.

## Test plan
- Reset, then sweep i_PC over 0x0..0x3C: o_Hit=0, o_PredTarget=0; one cycle later o_IFID_PcMatchValid=0 and o_IFID_Ctrl=01.
- Write PC=0x100, target=0x200, ctrl=10; next cycle i_PC=0x100: o_Hit=1, o_PredTaken=1, o_PredTarget=0x200; next cycle o_IFID_Ctrl=10.
- Same cycle: i_Upd_WE with PC=0x104, ctrl=11, and i_PC=0x104: o_Hit=1, o_PredTarget equals i_Upd_Target. Also i_PC=0x144 (ENTRIES=16, same index, different tag) while writing 0x104: miss.
- Write 0x100, then write 0x140 (alias): lookup 0x100 misses, lookup 0x140 hits, o_Upd_Count=2.
- i_Invalidate together with i_Upd_WE: all lookups miss afterwards and o_Upd_Count is unchanged. Assert i_Flush_IF_ID and i_IFID_Stall together: IF/ID register loads {0, 01, 0}.
- Force hits for 2^CNT_W+5 unstalled cycles: o_Hit_Count saturates at 0xFFFF. With i_PC_Stall=1 the count does not increment. Pulse rst low mid-run: counters and IF/ID register return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit prediction counters, a write-first
// update bypass, an IF/ID side register and saturating hit/update statistics.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      i_PC,
  input  logic             i_PC_Stall,
  input  logic             i_IFID_Stall,
  input  logic             i_Flush_IF_ID,
  input  logic             i_Invalidate,
  input  logic             i_Upd_WE,
  input  logic [31:0]      i_Upd_PC,
  input  logic [31:0]      i_Upd_Target,
  input  logic [1:0]       i_Upd_Ctrl,
  output logic             o_Hit,
  output logic             o_PredTaken,
  output logic [31:0]      o_PredTarget,
  output logic             o_IFID_PcMatchValid,
  output logic [1:0]       o_IFID_Ctrl,
  output logic [31:0]      o_IFID_Target,
  output logic [CNT_W-1:0] o_Hit_Count,
  output logic [CNT_W-1:0] o_Upd_Count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [1:0]       CTRL_WEAK_NT = 2'b01;
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctrl;
  } entry_t;

  entry_t             mem [ENTRIES];
  logic [ENTRIES-1:0] valid;

  logic [IDX_W-1:0] lu_idx, up_idx;
  logic [TAG_W-1:0] lu_tag, up_tag;
  logic             wr_accept, bypass, stored_hit;
  logic [1:0]       lu_ctrl;
  logic             unused_pc_bits;

  assign lu_idx = i_PC[IDX_W+1:2];
  assign lu_tag = i_PC[31:IDX_W+2];
  assign up_idx = i_Upd_PC[IDX_W+1:2];
  assign up_tag = i_Upd_PC[31:IDX_W+2];
  assign unused_pc_bits = ^{i_PC[1:0], i_Upd_PC[1:0]};

  // Invalidate wins over a same-cycle write: the write is dropped entirely.
  assign wr_accept  = i_Upd_WE && !i_Invalidate;
  assign bypass     = wr_accept && (up_idx == lu_idx) && (up_tag == lu_tag);
  assign stored_hit = valid[lu_idx] && (mem[lu_idx].tag == lu_tag);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    o_Hit        = 1'b0;
    o_PredTarget = 32'h0;
    lu_ctrl      = CTRL_WEAK_NT;
    if (bypass) begin
      o_Hit        = 1'b1;
      o_PredTarget = i_Upd_Target;
      lu_ctrl      = i_Upd_Ctrl;
    end else if (stored_hit) begin
      o_Hit        = 1'b1;
      o_PredTarget = mem[lu_idx].target;
      lu_ctrl      = mem[lu_idx].ctrl;
    end
  end

  assign o_PredTaken = o_Hit && lu_ctrl[1];

  // NOTE: tag/target/ctrl storage has no reset; the valid bits alone decide whether an entry is live.
  always_ff @(posedge clk) begin
    if (rst && wr_accept) begin
      mem[up_idx] <= '{tag: up_tag, target: i_Upd_Target, ctrl: i_Upd_Ctrl};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (i_Invalidate) begin
      valid <= '0;
    end else if (i_Upd_WE) begin
      valid[up_idx] <= 1'b1;
    end
  end

  // IF/ID side register: flush beats stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_IFID_PcMatchValid <= 1'b0;
      o_IFID_Ctrl         <= CTRL_WEAK_NT;
      o_IFID_Target       <= 32'h0;
    end else if (i_Flush_IF_ID) begin
      o_IFID_PcMatchValid <= 1'b0;
      o_IFID_Ctrl         <= CTRL_WEAK_NT;
      o_IFID_Target       <= 32'h0;
    end else if (!i_IFID_Stall) begin
      o_IFID_PcMatchValid <= o_Hit;
      o_IFID_Ctrl         <= lu_ctrl;
      o_IFID_Target       <= o_PredTarget;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_Hit_Count <= '0;
      o_Upd_Count <= '0;
    end else begin
      if (o_Hit && !i_PC_Stall && (o_Hit_Count != '1)) begin
        o_Hit_Count <= o_Hit_Count + CNT_ONE;
      end
      if (wr_accept && (o_Upd_Count != '1)) begin
        o_Upd_Count <= o_Upd_Count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized and directed bench for branch_target_buffer against a word-address
// reference model of the buffer contents, IF/ID register and statistics.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      pc, upd_pc, upd_tgt;
  logic [1:0]       upd_ctrl;
  logic             pc_stall, ifid_stall, flush, inval, we;
  logic             o_hit, o_taken, o_ifid_v;
  logic [31:0]      o_tgt, o_ifid_t;
  logic [1:0]       o_ifid_c;
  logic [CNT_W-1:0] o_hit_cnt, o_upd_cnt;

  branch_target_buffer #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_PC                (pc),
    .i_PC_Stall          (pc_stall),
    .i_IFID_Stall        (ifid_stall),
    .i_Flush_IF_ID       (flush),
    .i_Invalidate        (inval),
    .i_Upd_WE            (we),
    .i_Upd_PC            (upd_pc),
    .i_Upd_Target        (upd_tgt),
    .i_Upd_Ctrl          (upd_ctrl),
    .o_Hit               (o_hit),
    .o_PredTaken         (o_taken),
    .o_PredTarget        (o_tgt),
    .o_IFID_PcMatchValid (o_ifid_v),
    .o_IFID_Ctrl         (o_ifid_c),
    .o_IFID_Target       (o_ifid_t),
    .o_Hit_Count         (o_hit_cnt),
    .o_Upd_Count         (o_upd_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: each slot remembers the word address (PC/4) it was last written with.
  bit          m_valid [ENTRIES];
  logic [29:0] m_word  [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  logic [1:0]  m_ctrl  [ENTRIES];
  bit          m_ifid_v;
  logic [1:0]  m_ifid_c;
  logic [31:0] m_ifid_t;
  int          m_hit_cnt, m_upd_cnt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_ifid_v = 1'b0; m_ifid_c = 2'b01; m_ifid_t = 32'h0;
    m_hit_cnt = 0;   m_upd_cnt = 0;
  endtask

  task automatic check_regs();
    check("ifid_valid", o_ifid_v, m_ifid_v);
    check("ifid_ctrl", o_ifid_c, m_ifid_c);
    check("ifid_target", o_ifid_t, m_ifid_t);
    check("hit_count", o_hit_cnt, m_hit_cnt);
    check("upd_count", o_upd_cnt, m_upd_cnt);
  endtask

  task automatic predict(output bit h, output logic [31:0] t, output logic [1:0] c);
    int idx;
    logic [29:0] w, uw;
    w   = pc[31:2];
    uw  = upd_pc[31:2];
    idx = int'(w) % ENTRIES;
    h = 1'b0; t = 32'h0; c = 2'b01;
    if (we && !inval && uw == w) begin
      h = 1'b1; t = upd_tgt; c = upd_ctrl;
    end else if (m_valid[idx] && m_word[idx] == w) begin
      h = 1'b1; t = m_tgt[idx]; c = m_ctrl[idx];
    end
  endtask

  // Called just after an edge with inputs already driven; ends just after the next edge.
  task automatic cycle(input bit chk);
    bit h; logic [31:0] t; logic [1:0] c;
    int uidx;
    predict(h, t, c);
    #1;
    if (chk) begin
      check("hit", o_hit, h);
      check("pred_taken", o_taken, h & c[1]);
      check("pred_target", o_tgt, t);
    end
    @(posedge clk);
    if (flush) begin
      m_ifid_v = 1'b0; m_ifid_c = 2'b01; m_ifid_t = 32'h0;
    end else if (!ifid_stall) begin
      m_ifid_v = h; m_ifid_c = c; m_ifid_t = t;
    end
    if (h && !pc_stall && m_hit_cnt < CNT_MAX) m_hit_cnt++;
    if (inval) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (we) begin
      uidx = int'(upd_pc[31:2]) % ENTRIES;
      m_valid[uidx] = 1'b1; m_word[uidx] = upd_pc[31:2];
      m_tgt[uidx] = upd_tgt; m_ctrl[uidx] = upd_ctrl;
      if (m_upd_cnt < CNT_MAX) m_upd_cnt++;
    end
    #1;
    if (chk) check_regs();
  endtask

  task automatic idle(input logic [31:0] lookup_pc);
    pc = lookup_pc; we = 1'b0; inval = 1'b0; flush = 1'b0;
    ifid_stall = 1'b0; pc_stall = 1'b0;
  endtask

  task automatic write(input logic [31:0] lookup_pc, input logic [31:0] wpc,
                       input logic [31:0] wtgt, input logic [1:0] wctrl);
    idle(lookup_pc);
    we = 1'b1; upd_pc = wpc; upd_tgt = wtgt; upd_ctrl = wctrl;
  endtask

  function automatic logic [31:0] rand_pc();
    return ($urandom_range(0, 3) << 6) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    rst = 1'b0;
    idle(32'h0);
    upd_pc = 32'h0; upd_tgt = 32'h0; upd_ctrl = 2'b00;
    model_reset();
    #12;
    check_regs();
    rst = 1'b1;

    // Cold sweep: everything misses.
    for (int a = 0; a <= 32'h3C; a += 4) begin
      idle(a);
      cycle(1'b1);
    end

    // Write then hit on the next cycle.
    write(32'h0, 32'h100, 32'h200, 2'b10); cycle(1'b1);
    idle(32'h100); cycle(1'b1);
    idle(32'h100); cycle(1'b1);

    // Same-cycle bypass, and same index with a different tag (no bypass).
    write(32'h104, 32'h104, 32'hCAFE_0104, 2'b11); cycle(1'b1);
    write(32'h144, 32'h104, 32'hBEEF_0104, 2'b01); cycle(1'b1);
    idle(32'h104); cycle(1'b1);

    // Alias replacement.
    write(32'h0, 32'h100, 32'h300, 2'b11); cycle(1'b1);
    write(32'h0, 32'h140, 32'h400, 2'b10); cycle(1'b1);
    idle(32'h100); cycle(1'b1);
    idle(32'h140); cycle(1'b1);

    // Invalidate beats a same-cycle write; then flush beats stall.
    write(32'h140, 32'h108, 32'h500, 2'b11); inval = 1'b1; cycle(1'b1);
    idle(32'h108); cycle(1'b1);
    idle(32'h104); cycle(1'b1);
    idle(32'h140); cycle(1'b1);
    write(32'h0, 32'h10C, 32'h600, 2'b11); cycle(1'b1);
    idle(32'h10C); flush = 1'b1; ifid_stall = 1'b1; cycle(1'b1);
    idle(32'h10C); ifid_stall = 1'b1; cycle(1'b1);
    idle(32'h10C); pc_stall = 1'b1; cycle(1'b1);
    idle(32'h10C); cycle(1'b1);

    // Randomized traffic over a small PC pool so hits, aliases and bypasses are frequent.
    for (int n = 0; n < 600; n++) begin
      pc         = rand_pc();
      we         = ($urandom_range(0, 1) == 0);
      upd_pc     = ($urandom_range(0, 3) == 0) ? pc : rand_pc();
      upd_tgt    = $urandom();
      upd_ctrl   = 2'($urandom_range(0, 3));
      inval      = ($urandom_range(0, 19) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      ifid_stall = ($urandom_range(0, 3) == 0);
      pc_stall   = ($urandom_range(0, 3) == 0);
      cycle(1'b1);
    end

    // Hit counter saturation.
    write(32'h0, 32'h180, 32'h700, 2'b10); cycle(1'b1);
    idle(32'h180);
    for (int n = 0; n < (1 << CNT_W) + 5; n++) cycle(1'b0);
    cycle(1'b1);
    check("hit_count_sat", o_hit_cnt, 16'hFFFF);
    idle(32'h180); pc_stall = 1'b1; cycle(1'b1);

    // Asynchronous reset mid-run, held across an edge carrying a write.
    write(32'h0, 32'h1C0, 32'h800, 2'b11);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_regs();
    @(posedge clk);
    #1;
    check_regs();
    rst = 1'b1;
    idle(32'h1C0); cycle(1'b1);
    idle(32'h180); cycle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
